agc_gain_ctrl: RTL and testbench

- Automatic gain control stage that sits directly downstream of the DC-removal/average stage in the AGC chain.
- Consumes DC-free signed samples, applies a programmable fixed-point gain with rounding and saturation, and tracks the output peak over a fixed sample window.
- Steps the gain once per window, with hysteresis, so the output peak settles near a target level.
- Feeds the downstream DSP or capture path.

---
 rtl/agc_gain_ctrl_pkg.sv | 27 ++
 rtl/agc_gain_ctrl_sat_mul.sv | 89 ++++++++
 rtl/agc_gain_ctrl.sv | 152 +++++++++++++++
 tb/tb_agc_gain_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/agc_gain_ctrl_pkg.sv
// rtl/agc_gain_ctrl_pkg.sv - shared types and constants for the AGC gain stage
//
// Purpose: FSM state encoding, pipeline depth and saturation-limit helpers
//          shared by agc_gain_ctrl and agc_gain_ctrl_sat_mul.
// Ports:   none (package).
package agc_gain_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_ADJUST  = 2'd2
  } agc_state_t;

  // Number of ce-advanced registers between din and dout.
  localparam int PIPE_DEPTH = 2;

  // Largest positive value of a dw-bit two's complement sample.
  function automatic int sat_max(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  // Most negative value of a dw-bit two's complement sample.
  function automatic int sat_min(input int dw);
    return -(1 << (dw - 1));
  endfunction

endpackage

// File: rtl/agc_gain_ctrl_sat_mul.sv
// rtl/agc_gain_ctrl_sat_mul.sv - two-stage gain multiply, round and saturate pipeline
//
// Purpose: S1 registers din * {0,gain}; S2 rounds to nearest (half up), drops
//          FRAC bits, saturates to DW bits and registers into dout. Both stages
//          advance only on ce and carry a valid-bit chain.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   ce           sample strobe
//   din          signed input sample (DW)
//   gain         unsigned fixed-point gain (GW, FRAC fractional bits)
//   dout         registered saturated output sample (DW)
//   dout_valid   1-clk pulse when dout is written with a valid sample
//   clip         1-clk pulse with dout_valid when that sample saturated
//   dout_next    combinational value about to be registered into dout
//   wr           dout is being written with a valid sample this clk
//   pipe_valid   valid bits of S1 (bit 0) and S2 (bit 1)
module agc_gain_ctrl_sat_mul
  import agc_gain_ctrl_pkg::*;
#(
  parameter int DW   = 16,
  parameter int GW   = 16,
  parameter int FRAC = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [DW-1:0]         din,
  input  logic [GW-1:0]         gain,
  output logic [DW-1:0]         dout,
  output logic                  dout_valid,
  output logic                  clip,
  output logic [DW-1:0]         dout_next,
  output logic                  wr,
  output logic [PIPE_DEPTH-1:0] pipe_valid
);

  localparam int PW = DW + GW + 1;
  localparam logic [DW-1:0] SAT_MAX = DW'(sat_max(DW));
  localparam logic [DW-1:0] SAT_MIN = DW'(sat_min(DW));
  localparam logic signed [PW:0] RND_K = {{(PW + 1 - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};

  logic signed [PW-1:0] din_x;
  logic signed [PW-1:0] gain_x;
  logic signed [PW-1:0] prod_next;
  logic signed [PW-1:0] prod;
  logic signed [PW:0]   rnd;
  logic signed [PW:0]   shf;
  logic [PW-DW+1:0]     hi;
  logic                 sat;

  always_comb begin
    din_x     = {{(GW + 1){din[DW-1]}}, din};
    gain_x    = {{DW{1'b0}}, 1'b0, gain};
    prod_next = din_x * gain_x;
    rnd       = {prod[PW-1], prod} + RND_K;
    shf       = rnd >>> FRAC;
    // In range only when every bit above the DW-bit result equals its sign bit.
    hi        = shf[PW:DW-1];
    sat       = !((&hi) || (~|hi));
    if (!sat)
      dout_next = shf[DW-1:0];
    else if (shf[PW])
      dout_next = SAT_MIN;
    else
      dout_next = SAT_MAX;
    wr = ce && pipe_valid[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod       <= '0;
      pipe_valid <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      clip       <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      clip       <= 1'b0;
      if (ce) begin
        prod       <= prod_next;
        pipe_valid <= {pipe_valid[PIPE_DEPTH-2:0], 1'b1};
        dout       <= dout_next;
        dout_valid <= pipe_valid[0];
        clip       <= pipe_valid[0] && sat;
      end
    end
  end

endmodule

// File: rtl/agc_gain_ctrl.sv
// rtl/agc_gain_ctrl.sv - automatic gain control: gain, envelope peak and window FSM
//
// Purpose: applies a programmable gain to DC-free samples, tracks the output
//          peak over 2^WIN_LOG2 valid samples and steps the gain once per
//          window with hysteresis around TARGET.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   ce           sample strobe
//   din          signed input sample (DW)
//   freeze       hold the gain; windows are still measured
//   dout         signed gained, rounded, saturated sample (DW)
//   dout_valid   1-clk pulse when dout is written with a valid sample
//   clip         1-clk pulse with dout_valid when that sample saturated
//   gain         current applied gain (GW)
//   peak         peak magnitude of the last completed window (DW)
//   locked       last completed window peak was inside the dead band
module agc_gain_ctrl
  import agc_gain_ctrl_pkg::*;
#(
  parameter int DW        = 16,
  parameter int GW        = 16,
  parameter int FRAC      = 12,
  parameter int WIN_LOG2  = 8,
  parameter int TARGET    = 16384,
  parameter int HYST      = 1024,
  parameter int STEP      = 256,
  parameter int GAIN_INIT = 4096,
  parameter int GAIN_MIN  = 256,
  parameter int GAIN_MAX  = 65535
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ce,
  input  logic [DW-1:0] din,
  input  logic          freeze,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          clip,
  output logic [GW-1:0] gain,
  output logic [DW-1:0] peak,
  output logic          locked
);

  if ((TARGET - HYST) < 0 || (TARGET + HYST) > sat_max(DW) || GAIN_MAX > (2 ** GW) - 1) begin : g_bad_params
    $error("agc_gain_ctrl: TARGET/HYST outside sample range or GAIN_MAX wider than GW");
  end

  localparam logic [DW-1:0] SAT_MAX = DW'(sat_max(DW));
  localparam logic [DW-1:0] SAT_MIN = DW'(sat_min(DW));
  localparam logic [DW-1:0] THR_HI  = DW'(TARGET + HYST);
  localparam logic [DW-1:0] THR_LO  = DW'(TARGET - HYST);
  localparam logic [GW:0]   STEP_X  = (GW + 1)'(STEP);
  localparam logic [GW:0]   GMIN_X  = (GW + 1)'(GAIN_MIN);
  localparam logic [GW:0]   GMAX_X  = (GW + 1)'(GAIN_MAX);

  logic [DW-1:0]         dout_next;
  logic                  wr;
  logic [PIPE_DEPTH-1:0] pipe_valid;
  logic [DW-1:0]         mag;
  logic [DW-1:0]         pk_new;
  logic [DW-1:0]         run_pk;
  logic [DW-1:0]         win_max;
  logic [WIN_LOG2-1:0]   win_cnt;
  logic [GW:0]           g_dn;
  logic [GW:0]           g_up;
  agc_state_t            state;

  agc_gain_ctrl_sat_mul #(
    .DW   (DW),
    .GW   (GW),
    .FRAC (FRAC)
  ) u_sat_mul (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .din        (din),
    .gain       (gain),
    .dout       (dout),
    .dout_valid (dout_valid),
    .clip       (clip),
    .dout_next  (dout_next),
    .wr         (wr),
    .pipe_valid (pipe_valid)
  );

  always_comb begin
    // The saturated negative limit has no positive twin; report it as SAT_MAX.
    if (dout_next == SAT_MIN)
      mag = SAT_MAX;
    else if (dout_next[DW-1])
      mag = -dout_next;
    else
      mag = dout_next;
    pk_new = (mag > run_pk) ? mag : run_pk;
    // One extra bit so the step can neither wrap below zero nor overflow GW.
    g_dn = {1'b0, gain} - STEP_X;
    g_up = {1'b0, gain} + STEP_X;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_FILL;
      win_cnt <= '0;
      run_pk  <= '0;
      win_max <= '0;
      gain    <= GW'(GAIN_INIT);
      peak    <= '0;
      locked  <= 1'b0;
    end else begin
      case (state)
        ST_FILL: begin
          if (&pipe_valid)
            state <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (wr) begin
            win_cnt <= win_cnt + WIN_LOG2'(1);
            if (&win_cnt) begin
              win_max <= pk_new;
              run_pk  <= '0;
              state   <= ST_ADJUST;
            end else begin
              run_pk <= pk_new;
            end
          end
        end
        ST_ADJUST: begin
          // A sample landing here already belongs to the new window.
          if (wr) begin
            run_pk  <= mag;
            win_cnt <= win_cnt + WIN_LOG2'(1);
          end
          peak <= win_max;
          if (!freeze) begin
            if (win_max > THR_HI) begin
              gain   <= (g_dn[GW] || g_dn < GMIN_X) ? GW'(GAIN_MIN) : g_dn[GW-1:0];
              locked <= 1'b0;
            end else if (win_max < THR_LO) begin
              gain   <= (g_up > GMAX_X) ? GW'(GAIN_MAX) : g_up[GW-1:0];
              locked <= 1'b0;
            end else begin
              locked <= 1'b1;
            end
          end
          state <= ST_MEASURE;
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// tb/tb_agc_gain_ctrl.sv - directed self-checking bench for agc_gain_ctrl
module tb_agc_gain_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        freeze;
  logic [15:0] din;

  logic [15:0] dout_w [3];
  logic [15:0] gain_w [3];
  logic [15:0] peak_w [3];
  logic        dv_w   [3];
  logic        clip_w [3];
  logic        lock_w [3];

  int n_chk  = 0;
  int n_fail = 0;

  int pts [4] = '{258, 259, 515, 771};
  int snap_g [3][4];
  int snap_p [3][4];
  int snap_l [3][4];

  typedef struct {
    int din;
    bit ce;
    bit v;
    int d0;
    bit c0;
    int d1;
    bit c1;
    int d2;
    bit c2;
  } vec_t;
  vec_t tbl [9];

  always #5 clk = ~clk;

  agc_gain_ctrl dut0 (
    .clk(clk), .reset(reset), .ce(ce), .din(din), .freeze(freeze),
    .dout(dout_w[0]), .dout_valid(dv_w[0]), .clip(clip_w[0]),
    .gain(gain_w[0]), .peak(peak_w[0]), .locked(lock_w[0])
  );

  agc_gain_ctrl #(.GAIN_INIT(8192)) dut1 (
    .clk(clk), .reset(reset), .ce(ce), .din(din), .freeze(freeze),
    .dout(dout_w[1]), .dout_valid(dv_w[1]), .clip(clip_w[1]),
    .gain(gain_w[1]), .peak(peak_w[1]), .locked(lock_w[1])
  );

  agc_gain_ctrl #(.GAIN_INIT(65535)) dut2 (
    .clk(clk), .reset(reset), .ce(ce), .din(din), .freeze(freeze),
    .dout(dout_w[2]), .dout_valid(dv_w[2]), .clip(clip_w[2]),
    .gain(gain_w[2]), .peak(peak_w[2]), .locked(lock_w[2])
  );

  function automatic int sv(input logic [15:0] x);
    return int'($signed(x));
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    ce     = 1'b0;
    din    = '0;
    freeze = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Continuous stream; amplitude chosen by the window the sample is captured in.
  task automatic run(input int n, input int a0, input int a1, input int a2,
                     input bit alt, input int frz_lo, input int frz_hi, input int ce_off);
    for (int d = 0; d < 3; d++)
      for (int p = 0; p < 4; p++) begin
        snap_g[d][p] = -1;
        snap_p[d][p] = -1;
        snap_l[d][p] = -1;
      end
    for (int k = 0; k < n; k++) begin
      int a;
      a      = (k < 258) ? a0 : (k < 514) ? a1 : a2;
      din    = (alt && (k % 2 == 0)) ? 16'(a) : 16'(-a);
      freeze = (k >= frz_lo) && (k <= frz_hi);
      ce     = (k != ce_off);
      @(posedge clk);
      #1;
      for (int p = 0; p < 4; p++)
        if (k == pts[p])
          for (int d = 0; d < 3; d++) begin
            snap_g[d][p] = int'(gain_w[d]);
            snap_p[d][p] = int'(peak_w[d]);
            snap_l[d][p] = int'(lock_w[d]);
          end
    end
    ce     = 1'b0;
    freeze = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1000,   1'b1, 1'b0, 0,      1'b0, 0,      1'b0, 0,      1'b0};
    tbl[1] = '{-1000,  1'b1, 1'b1, 1000,   1'b0, 2000,   1'b0, 16000,  1'b0};
    tbl[2] = '{20000,  1'b1, 1'b1, -1000,  1'b0, -2000,  1'b0, -16000, 1'b0};
    tbl[3] = '{-20000, 1'b0, 1'b0, -1000,  1'b0, -2000,  1'b0, -16000, 1'b0};
    tbl[4] = '{-20000, 1'b1, 1'b1, 20000,  1'b0, 32767,  1'b1, 32767,  1'b1};
    tbl[5] = '{0,      1'b1, 1'b1, -20000, 1'b0, -32768, 1'b1, -32768, 1'b1};
    tbl[6] = '{1,      1'b1, 1'b1, 0,      1'b0, 0,      1'b0, 0,      1'b0};
    tbl[7] = '{-1,     1'b1, 1'b1, 1,      1'b0, 2,      1'b0, 16,     1'b0};
    tbl[8] = '{0,      1'b1, 1'b1, -1,     1'b0, -2,     1'b0, -16,    1'b0};

    reset = 1'b1; ce = 1'b0; din = '0; freeze = 1'b0;
    do_reset();

    // Reset values
    for (int d = 0; d < 3; d++) begin
      chk("rst_dout", sv(dout_w[d]), 0);
      chk("rst_dout_valid", int'(dv_w[d]), 0);
      chk("rst_clip", int'(clip_w[d]), 0);
      chk("rst_peak", int'(peak_w[d]), 0);
      chk("rst_locked", int'(lock_w[d]), 0);
    end
    chk("rst_gain_4096", int'(gain_w[0]), 4096);
    chk("rst_gain_8192", int'(gain_w[1]), 8192);
    chk("rst_gain_65535", int'(gain_w[2]), 65535);

    // Datapath vectors: latency, ce stall, rounding, saturation
    for (int i = 0; i < 9; i++) begin
      din = 16'(tbl[i].din);
      ce  = tbl[i].ce;
      @(posedge clk);
      #1;
      chk("vec_valid", int'(dv_w[0]), int'(tbl[i].v));
      chk("vec_dout_g4096", sv(dout_w[0]), tbl[i].d0);
      chk("vec_clip_g4096", int'(clip_w[0]), int'(tbl[i].c0));
      chk("vec_dout_g8192", sv(dout_w[1]), tbl[i].d1);
      chk("vec_clip_g8192", int'(clip_w[1]), int'(tbl[i].c1));
      chk("vec_dout_g65535", sv(dout_w[2]), tbl[i].d2);
      chk("vec_clip_g65535", int'(clip_w[2]), int'(tbl[i].c2));
    end
    ce = 1'b0;

    // Gain ramp-up over three windows
    do_reset();
    run(772, 4000, 4000, 4000, 1'b1, -1, -1, -1);
    chk("ramp_peak_before_adjust", snap_p[0][0], 0);
    chk("ramp_gain_before_adjust", snap_g[0][0], 4096);
    chk("ramp_w1_peak", snap_p[0][1], 4000);
    chk("ramp_w1_gain", snap_g[0][1], 4352);
    chk("ramp_w1_locked", snap_l[0][1], 0);
    chk("ramp_w2_peak", snap_p[0][2], 4250);
    chk("ramp_w2_gain", snap_g[0][2], 4608);
    chk("ramp_w3_peak", snap_p[0][3], 4500);
    chk("ramp_w3_gain", snap_g[0][3], 4864);
    chk("ramp_w3_locked", snap_l[0][3], 0);
    chk("ramp_g8192_peak", snap_p[1][1], 8000);
    chk("ramp_g8192_gain", snap_g[1][1], 8448);
    chk("ramp_g65535_peak", snap_p[2][1], 32767);
    chk("ramp_g65535_gain", snap_g[2][1], 65279);

    // Lock in band, frozen window, then step down
    do_reset();
    run(772, 15500, 30000, 18000, 1'b1, 260, 515, -1);
    chk("lock_w1_peak", snap_p[0][1], 15500);
    chk("lock_w1_gain", snap_g[0][1], 4096);
    chk("lock_w1_locked", snap_l[0][1], 1);
    chk("freeze_w2_peak", snap_p[0][2], 30000);
    chk("freeze_w2_gain", snap_g[0][2], 4096);
    chk("freeze_w2_locked", snap_l[0][2], 1);
    chk("freeze_g8192_peak", snap_p[1][2], 32767);
    chk("freeze_g8192_gain", snap_g[1][2], 7936);
    chk("down_w3_peak", snap_p[0][3], 18000);
    chk("down_w3_gain", snap_g[0][3], 3840);
    chk("down_w3_locked", snap_l[0][3], 0);

    // Small input: upper clamp; ce dropped on the ADJUST clock
    do_reset();
    run(260, 100, 100, 100, 1'b1, -1, -1, 259);
    chk("small_g4096_peak", snap_p[0][1], 100);
    chk("small_g4096_gain", snap_g[0][1], 4352);
    chk("small_g8192_peak", snap_p[1][1], 200);
    chk("small_g8192_gain", snap_g[1][1], 8448);
    chk("clamp_g65535_peak", snap_p[2][1], 1600);
    chk("clamp_g65535_gain", snap_g[2][1], 65535);

    // Constant negative input: negative saturation maps to max magnitude
    do_reset();
    run(260, 20000, 20000, 20000, 1'b0, -1, -1, -1);
    chk("neg_g4096_peak", snap_p[0][1], 20000);
    chk("neg_g4096_gain", snap_g[0][1], 3840);
    chk("neg_g8192_peak", snap_p[1][1], 32767);
    chk("neg_g8192_gain", snap_g[1][1], 7936);
    chk("neg_g65535_peak", snap_p[2][1], 32767);
    chk("neg_g65535_gain", snap_g[2][1], 65279);

    // Reset after 100 valid samples discards the partial window
    do_reset();
    run(101, 16000, 16000, 16000, 1'b1, -1, -1, -1);
    chk("pre_reset_dout", sv(dout_w[0]), -16000);
    #2 reset = 1'b1;
    #1;
    chk("midrst_dout", sv(dout_w[0]), 0);
    chk("midrst_dout_valid", int'(dv_w[0]), 0);
    chk("midrst_gain", int'(gain_w[0]), 4096);
    chk("midrst_peak", int'(peak_w[0]), 0);
    chk("midrst_locked", int'(lock_w[0]), 0);
    chk("midrst_gain_65535", int'(gain_w[2]), 65535);
    @(posedge clk);
    #1 reset = 1'b0;
    run(260, 8000, 8000, 8000, 1'b1, -1, -1, -1);
    chk("after_rst_peak_before_adjust", snap_p[0][0], 0);
    chk("after_rst_peak", snap_p[0][1], 8000);
    chk("after_rst_gain", snap_g[0][1], 4352);
    chk("after_rst_locked", snap_l[0][1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
